// File: rtl/accumulator_cpu_core.sv
// Single-cycle 8-bit accumulator core: every instruction fetches, decodes and retires in one clock; no backpressure.
// Optional PROG_WRITE_EN adds a program-memory write port (PW_EN/PW_ADDR/PW_DATA) usable during reset.
module accumulator_cpu_core #(
   parameter int DATA_WIDTH = 8,
   parameter int PC_WIDTH   = 4,
   parameter int ROM_WIDTH  = 4 + DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
`ifdef PROG_WRITE_EN
   input  logic                  PW_EN,
   input  logic [PC_WIDTH-1:0]   PW_ADDR,
   input  logic [ROM_WIDTH-1:0]  PW_DATA,
`endif
   output logic [PC_WIDTH-1:0]   PC,
   output logic [ROM_WIDTH-1:0]  INSTR,
   output logic [DATA_WIDTH-1:0] ACC_OUT,
   output logic [DATA_WIDTH-1:0] R0_OUT
);

   localparam int DEPTH = 2 ** PC_WIDTH;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10,
      ALU_AND  = 2'b11
   } alu_op_t;

   function automatic logic [ROM_WIDTH-1:0] mk_word(input logic [3:0] opc, input int imm);
      return {opc, DATA_WIDTH'(imm)};
   endfunction

   function automatic logic [ROM_WIDTH-1:0] default_word(input logic [PC_WIDTH-1:0] addr);
      case (int'(addr))
         0:       return mk_word(4'h1, 5);
         1:       return mk_word(4'h3, 0);
         2:       return mk_word(4'h1, 3);
         3:       return mk_word(4'h4, 0);
         4:       return mk_word(4'h3, 0);
         5:       return mk_word(4'h5, 0);
         6:       return mk_word(4'h7, 16);
         7:       return mk_word(4'h9, 15);
         8:       return mk_word(4'h8, 2);
         9:       return mk_word(4'hF, 0);
         default: return '0;
      endcase
   endfunction

   logic [PC_WIDTH-1:0]   pc_r;
   logic [DATA_WIDTH-1:0] acc_r;
   logic [DATA_WIDTH-1:0] r0_r;
   logic [ROM_WIDTH-1:0]  instr;

`ifdef PROG_WRITE_EN
   // Words never written fall back to the default program, so power-up
   // contents match the ROM build without a memory-clearing reset.
   logic [ROM_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]     written = '0;

   always_ff @(posedge CLK) begin
      if (PW_EN) begin
         mem[PW_ADDR]     <= PW_DATA;
         written[PW_ADDR] <= 1'b1;
      end
   end

   assign instr = written[pc_r] ? mem[pc_r] : default_word(pc_r);
`else
   assign instr = default_word(pc_r);
`endif

   logic [3:0]            opcode;
   logic [DATA_WIDTH-1:0] imm;
   logic                  reset_instr;
   logic                  sel;
   logic                  ce_r0;
   logic                  ce_acc;
   alu_op_t               op;

   assign opcode = instr[ROM_WIDTH-1 -: 4];
   assign imm    = instr[DATA_WIDTH-1:0];

   always_comb begin
      reset_instr = 1'b0;
      sel         = 1'b0;
      ce_r0       = 1'b0;
      ce_acc      = 1'b0;
      op          = ALU_PASS;
      case (opcode)
         4'h1: begin sel = 1'b1; ce_acc = 1'b1; op = ALU_PASS; end
         4'h3: ce_r0 = 1'b1;
         4'h4: begin ce_acc = 1'b1; op = ALU_ADD; end
         4'h5: begin ce_acc = 1'b1; op = ALU_SUB; end
         4'h6: begin ce_acc = 1'b1; op = ALU_AND; end
         4'h7: begin sel = 1'b1; ce_acc = 1'b1; op = ALU_ADD; end
         4'h8: begin sel = 1'b1; ce_acc = 1'b1; op = ALU_SUB; end
         4'h9: begin sel = 1'b1; ce_acc = 1'b1; op = ALU_AND; end
         4'hF: reset_instr = 1'b1;
         default: ;
      endcase
   end

   logic [DATA_WIDTH-1:0] alu_in0;
   logic [DATA_WIDTH-1:0] alu_res;

   assign alu_in0 = sel ? imm : acc_r;

   always_comb begin
      alu_res = alu_in0;
      case (op)
         ALU_PASS: alu_res = alu_in0;
         ALU_ADD:  alu_res = alu_in0 + r0_r;
         ALU_SUB:  alu_res = alu_in0 - r0_r;
         ALU_AND:  alu_res = alu_in0 & r0_r;
         default:  alu_res = alu_in0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_r  <= '0;
         acc_r <= '0;
         r0_r  <= '0;
      end else begin
         pc_r <= reset_instr ? '0 : pc_r + PC_WIDTH'(1);
         if (ce_acc) acc_r <= alu_res;
         if (ce_r0)  r0_r  <= acc_r;
      end
   end

   assign PC      = pc_r;
   assign INSTR   = instr;
   assign ACC_OUT = acc_r;
   assign R0_OUT  = r0_r;

endmodule

// File: tb/tb_accumulator_cpu_core.sv
// Randomized bench for accumulator_cpu_core against an instruction-level reference model.
module tb_accumulator_cpu_core;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  PC;
   logic [11:0] INSTR;
   logic [7:0]  ACC_OUT;
   logic [7:0]  R0_OUT;
`ifdef PROG_WRITE_EN
   logic        PW_EN   = 1'b0;
   logic [3:0]  PW_ADDR = '0;
   logic [11:0] PW_DATA = '0;
`endif

   int errors = 0;
   int checks = 0;

   logic [11:0] m_mem [16] = '{12'h105, 12'h300, 12'h103, 12'h400, 12'h300, 12'h500,
                               12'h710, 12'h90F, 12'h802, 12'hF00, 12'h000, 12'h000,
                               12'h000, 12'h000, 12'h000, 12'h000};
   logic [11:0] dflt [16];
   logic [3:0]  m_pc  = '0;
   logic [7:0]  m_acc = '0;
   logic [7:0]  m_r0  = '0;

   accumulator_cpu_core dut (
      .CLK     (CLK),
      .RST     (RST),
`ifdef PROG_WRITE_EN
      .PW_EN   (PW_EN),
      .PW_ADDR (PW_ADDR),
      .PW_DATA (PW_DATA),
`endif
      .PC      (PC),
      .INSTR   (INSTR),
      .ACC_OUT (ACC_OUT),
      .R0_OUT  (R0_OUT)
   );

   always #5 CLK = ~CLK;

   // Architectural effect of one instruction at a rising edge.
   task automatic model_step(input bit rst);
      logic [11:0] w;
      logic [3:0]  opc;
      logic [7:0]  imm;
      w   = m_mem[m_pc];
      opc = w[11:8];
      imm = w[7:0];
      if (rst) begin
         m_pc = 0; m_acc = 0; m_r0 = 0;
      end else begin
         case (opc)
            4'h1: m_acc = imm;
            4'h3: m_r0  = m_acc;
            4'h4: m_acc = m_acc + m_r0;
            4'h5: m_acc = m_acc - m_r0;
            4'h6: m_acc = m_acc & m_r0;
            4'h7: m_acc = imm + m_r0;
            4'h8: m_acc = imm - m_r0;
            4'h9: m_acc = imm & m_r0;
            default: ;
         endcase
         m_pc = (opc == 4'hF) ? 4'd0 : m_pc + 4'd1;
      end
   endtask

   // One clock: inputs already driven, model advanced, outputs settled 1ns after the edge.
   task automatic cycle();
      bit r;
`ifdef PROG_WRITE_EN
      bit          we;
      logic [3:0]  wa;
      logic [11:0] wd;
      we = PW_EN; wa = PW_ADDR; wd = PW_DATA;
`endif
      r = RST;
      @(posedge CLK);
      #1;
      model_step(r);
`ifdef PROG_WRITE_EN
      if (we) m_mem[wa] = wd;
`endif
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat ($urandom_range(3, 17)) cycle();
      RST = 1'b1;
      cycle();
      cycle();
      checks++;
      if ({PC, ACC_OUT, R0_OUT, INSTR} !== {4'd0, 8'h00, 8'h00, 12'h105}) begin
         errors++;
         $display("FAIL reset: PC=%0d ACC=%h R0=%h INSTR=%h, want 0 00 00 105", PC, ACC_OUT, R0_OUT, INSTR);
      end
   endtask

   task automatic test_default_program();
      logic [7:0] exp_acc [10] = '{8'h05, 8'h05, 8'h03, 8'h08, 8'h08, 8'h00, 8'h18, 8'h08, 8'hFA, 8'hFA};
      logic [7:0] exp_r0  [10] = '{8'h00, 8'h05, 8'h05, 8'h05, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08};
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      for (int e = 0; e < 10; e++) begin
         cycle();
         checks++;
         if (ACC_OUT !== exp_acc[e] || R0_OUT !== exp_r0[e]) begin
            errors++;
            $display("FAIL prog edge %0d: ACC=%h R0=%h, want %h %h", e + 1, ACC_OUT, R0_OUT, exp_acc[e], exp_r0[e]);
         end
      end
      checks++;
      if (PC !== 4'd0) begin
         errors++;
         $display("FAIL jrst pc: PC=%0d, want 0", PC);
      end
   endtask

   task automatic test_loop();
      cycle();
      checks++;
      if (ACC_OUT !== 8'h05 || PC !== 4'd1) begin
         errors++;
         $display("FAIL loop edge 11: ACC=%h PC=%0d, want 05 1", ACC_OUT, PC);
      end
      repeat (40) begin
         cycle();
         checks++;
         if (PC > 4'd9 || {PC, INSTR, ACC_OUT, R0_OUT} !== {m_pc, m_mem[m_pc], m_acc, m_r0}) begin
            errors++;
            $display("FAIL loop: PC=%0d ACC=%h R0=%h, want PC=%0d ACC=%h R0=%h", PC, ACC_OUT, R0_OUT, m_pc, m_acc, m_r0);
         end
      end
   endtask

   task automatic test_mid_reset();
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      repeat (4) cycle();
      checks++;
      if (PC !== 4'd4 || R0_OUT !== 8'h05) begin
         errors++;
         $display("FAIL mid setup: PC=%0d R0=%h, want 4 05", PC, R0_OUT);
      end
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      checks++;
      if ({PC, ACC_OUT, R0_OUT} !== {4'd0, 8'h00, 8'h00}) begin
         errors++;
         $display("FAIL mid reset: PC=%0d ACC=%h R0=%h, want 0 00 00", PC, ACC_OUT, R0_OUT);
      end
   endtask

   task automatic test_random_resets();
      repeat (200) begin
         RST = ($urandom_range(0, 11) == 0);
         cycle();
         checks++;
         if ({PC, INSTR, ACC_OUT, R0_OUT} !== {m_pc, m_mem[m_pc], m_acc, m_r0}) begin
            errors++;
            $display("FAIL rand reset: PC=%0d INSTR=%h ACC=%h R0=%h, want %0d %h %h %h",
                     PC, INSTR, ACC_OUT, R0_OUT, m_pc, m_mem[m_pc], m_acc, m_r0);
         end
      end
      RST = 1'b0;
   endtask

`ifdef PROG_WRITE_EN
   task automatic test_undef_wrap();
      RST = 1'b1;
      for (int i = 0; i < 16; i++) begin
         PW_EN = 1'b1; PW_ADDR = 4'(i); PW_DATA = (i == 0) ? 12'h2AA : 12'h000;
         cycle();
      end
      PW_EN = 1'b0;
      cycle();
      RST = 1'b0;
      checks++;
      if (INSTR !== 12'h2AA) begin
         errors++;
         $display("FAIL undef load: INSTR=%h, want 2aa", INSTR);
      end
      for (int k = 1; k <= 20; k++) begin
         cycle();
         checks++;
         if ({PC, ACC_OUT, R0_OUT} !== {4'(k % 16), 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL wrap %0d: PC=%0d ACC=%h R0=%h, want %0d 00 00", k, PC, ACC_OUT, R0_OUT, k % 16);
         end
      end
   endtask

   task automatic test_write_during_fetch();
      RST = 1'b1;
      for (int i = 0; i < 16; i++) begin
         PW_EN = 1'b1; PW_ADDR = 4'(i); PW_DATA = dflt[i];
         cycle();
      end
      PW_EN = 1'b0;
      cycle();
      RST = 1'b0;
      PW_EN = 1'b1; PW_ADDR = 4'd1; PW_DATA = 12'h1AB;
      cycle();
      PW_EN = 1'b0;
      checks++;
      if (ACC_OUT !== 8'h05 || INSTR !== 12'h1AB) begin
         errors++;
         $display("FAIL wr fetch: ACC=%h INSTR=%h, want 05 1ab", ACC_OUT, INSTR);
      end
      cycle();
      checks++;
      if (ACC_OUT !== 8'hAB) begin
         errors++;
         $display("FAIL wr exec: ACC=%h, want ab", ACC_OUT);
      end
   endtask

   task automatic test_random_program();
      RST = 1'b1;
      for (int i = 0; i < 16; i++) begin
         PW_EN = 1'b1; PW_ADDR = 4'(i); PW_DATA = 12'($urandom);
         cycle();
      end
      PW_EN = 1'b0;
      cycle();
      RST = 1'b0;
      repeat (300) begin
         PW_EN   = ($urandom_range(0, 7) == 0);
         PW_ADDR = 4'($urandom);
         PW_DATA = 12'($urandom);
         RST     = ($urandom_range(0, 40) == 0);
         cycle();
         checks++;
         if ({PC, INSTR, ACC_OUT, R0_OUT} !== {m_pc, m_mem[m_pc], m_acc, m_r0}) begin
            errors++;
            $display("FAIL rand prog: PC=%0d INSTR=%h ACC=%h R0=%h, want %0d %h %h %h",
                     PC, INSTR, ACC_OUT, R0_OUT, m_pc, m_mem[m_pc], m_acc, m_r0);
         end
      end
      PW_EN = 1'b0;
      RST   = 1'b0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) dflt[i] = m_mem[i];
      test_reset();
      test_default_program();
      test_loop();
      test_mid_reset();
      test_random_resets();
`ifdef PROG_WRITE_EN
      test_undef_wrap();
      test_write_during_fetch();
      test_random_program();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/accumulator_cpu_core.md
Name: accumulator_cpu_core

Overview:
Self-contained 8-bit accumulator microprocessor core. It contains:
- program counter
- 16x12 program memory
- instruction decoder
- 2-bit-opcode ALU
- accumulator ACC and operand register R0
- ALU input mux

Each instruction executes in one clock, with no pipeline. The core is the top-level compute block of the microprocessor.

Parameters:
- DATA_WIDTH, 8: width of ACC, R0, ALU and immediate field.
- PC_WIDTH, 4: program counter width; memory depth is 2**PC_WIDTH.
- ROM_WIDTH, 12: instruction width, fixed at 4 + DATA_WIDTH. Bits [11:8] are the opcode; bits [7:0] are the immediate.

Ports:
- CLK  input  1  Single clock; all state changes on the rising edge.
- RST  input  1  Synchronous, active-high reset.
- PC  output  PC_WIDTH  Current program counter.
- INSTR  output  ROM_WIDTH  Instruction currently fetched from memory[PC].
- ACC_OUT  output  DATA_WIDTH  Accumulator value.
- R0_OUT  output  DATA_WIDTH  R0 value.

Behaviour:
Reset and PC sequencing:
- RST=1 at a rising edge sets PC=0, ACC=0 and R0=0. RST has priority over every instruction.
- INSTR = memory[PC], read combinationally. The decoder and ALU are combinational.
- PC increments at each edge. It wraps from 15 to 0.

ALU:
- IN0 = mux output: ACC when SEL=0, imm when SEL=1. IN1 = R0.
- OP 00: PASS (result = IN0).
- OP 01: ADD (IN0 + IN1).
- OP 10: SUB (IN0 - IN1).
- OP 11: AND.
- Results are modulo 2**DATA_WIDTH. There are no flags.

Opcodes (bits [11:8]); each executes at the next rising edge:
- 0x0 NOP: no register change.
- 0x1 LDI: ACC <= imm (SEL=1, PASS).
- 0x3 MOV: R0 <= ACC (old ACC value). ACC unchanged.
- 0x4 ADD: ACC <= ACC + R0.
- 0x5 SUB: ACC <= ACC - R0.
- 0x6 AND: ACC <= ACC & R0.
- 0x7 ADDI: ACC <= imm + R0.
- 0x8 SUBI: ACC <= imm - R0.
- 0x9 ANDI: ACC <= imm & R0.
- 0xF JRST: next PC = 0. ACC and R0 unchanged.
- All other opcodes (0x2, 0xA-0xE) behave as NOP.

Decoder outputs:
- Internal signals RESET_INSTR, SEL, CE_R0, CE_ACC, OP.
- CE_ACC and CE_R0 are never both 1.
- Disabled registers hold their value.

Default program memory contents (address: word):
- 0: 0x105
- 1: 0x300
- 2: 0x103
- 3: 0x400
- 4: 0x300
- 5: 0x500
- 6: 0x710
- 7: 0x90F
- 8: 0x802
- 9: 0xF00
- 10-15: 0x000

Optional Feature:
Macro PROG_WRITE_EN.

When defined:
- Adds input ports PW_EN (1), PW_ADDR (PC_WIDTH) and PW_DATA (ROM_WIDTH).
- When PW_EN=1 at a rising edge, memory[PW_ADDR] <= PW_DATA. Writes are accepted while RST=1, so the program can be loaded under reset.
- The instruction executing at that edge uses the old contents. INSTR shows the new word from the next cycle if PW_ADDR == PC.
- Memory is not cleared by RST.

When undefined:
- Memory is a constant ROM holding the default contents, with no write ports.

Test Plan:
1. Reset: hold RST=1 for 2 edges from arbitrary state -> PC=0, ACC=0x00, R0=0x00, INSTR=0x105.
2. Default program from reset, ACC/R0 after each edge:
   - edge 1: ACC=0x05
   - edge 2: R0=0x05
   - edge 3: ACC=0x03
   - edge 4: ACC=0x08
   - edge 5: R0=0x08
   - edge 6: ACC=0x00
   - edge 7: ACC=0x18
   - edge 8: ACC=0x08
   - edge 9: ACC=0xFA
   - edge 10: PC=0, ACC=0xFA, R0=0x08 retained
3. Loop: after the JRST at edge 10, the sequence repeats. Edge 11 gives ACC=0x05. PC never exceeds 9.
4. Mid-program reset: assert RST at the edge where PC=4 -> PC=0, ACC=0, R0=0. The MOV at address 4 is not executed.
5. Undefined opcode and wrap: with PROG_WRITE_EN, load 0x2AA at address 0 and NOPs elsewhere -> ACC and R0 stay 0. PC counts 0..15, then wraps to 0.
6. PROG_WRITE_EN write-during-fetch:
   - Release RST. At the edge executing address 0, write 0x1AB to address 1 -> after that edge ACC=0x05 and INSTR=0x1AB.
   - Next edge -> ACC=0xAB.
